// File: rtl/csa_accum_pkg.sv
// csa_accum_pkg
//   Shared types and sizing helpers for the carry-save accumulating sequencer.
//   - state_t      : sequencer state encoding (IDLE, ACCUM, RESOLVE, DONE)
//   - calc_acc_w   : accumulator width, N + clog2(MAX_OPS)
//   - calc_slices  : number of CHUNK-bit slices needed to resolve ACC_W bits
//   - calc_cnt_w   : width of an operand counter that reaches MAX_OPS
//   - calc_idx_w   : width of a slice index (at least 1 bit)
package csa_accum_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ACCUM   = 2'd1,
      RESOLVE = 2'd2,
      DONE    = 2'd3
   } state_t;

   function automatic int calc_acc_w(input int n, input int max_ops);
      return n + $clog2(max_ops);
   endfunction

   function automatic int calc_slices(input int acc_w, input int chunk);
      return (acc_w + chunk - 1) / chunk;
   endfunction

   function automatic int calc_cnt_w(input int max_ops);
      return $clog2(max_ops + 1);
   endfunction

   function automatic int calc_idx_w(input int slices);
      return (slices > 1) ? $clog2(slices) : 1;
   endfunction

endpackage

// File: rtl/csa_compress_3to2.sv
// csa_compress_3to2
//   One row of W full adders: compresses three W-bit vectors into a redundant
//   (sum, carry) pair with a + b + c == sum + carry (mod 2^W).
//   The carry vector is already shifted left by one; the adder carry out of
//   bit W-1 is dropped because the accumulator width is sized so it is zero.
// Ports
//   a, b, c : in  W  addends
//   sum     : out W  bitwise sum
//   carry   : out W  majority vector, pre-shifted by one position
module csa_compress_3to2
   import csa_accum_pkg::*;
#(
   parameter int W = 36
) (
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   input  logic [W-1:0] c,
   output logic [W-1:0] sum,
   output logic [W-1:0] carry
);

   assign sum   = a ^ b ^ c;
   assign carry = {(a[W-2:0] & b[W-2:0]) |
                   (a[W-2:0] & c[W-2:0]) |
                   (b[W-2:0] & c[W-2:0]), 1'b0};

endmodule

// File: rtl/csa_accum_sequencer.sv
// csa_accum_sequencer
//   Streams up to MAX_OPS unsigned N-bit operands into a redundant (sum, carry)
//   accumulator, one 3:2 compression per accepted beat. The group closes on
//   in_last or when MAX_OPS operands have been taken; the redundant pair is
//   then resolved with a CHUNK-bit sliced carry-propagate add (one slice per
//   cycle) and the ACC_W-bit total is offered on a valid/ready output.
//   Optional feature macro: CSA_ACC_SAT_EN -- when defined, a total that does
//   not fit in N bits is presented as all-ones N bits and out_sat is raised.
// Ports
//   clk        in   1      rising-edge clock
//   rst_n      in   1      asynchronous active-low reset
//   in_valid   in   1      operand valid
//   in_ready   out  1      operand accepted when in_valid & in_ready
//   in_data    in   N      unsigned operand
//   in_last    in   1      final operand of the group
//   out_valid  out  1      result valid
//   out_ready  in   1      consumer accepts result
//   out_result out  ACC_W  accumulated total
//   out_trunc  out  1      group closed by the operand limit, not by in_last
//   out_sat    out  1      result saturated (CSA_ACC_SAT_EN only, else 0)
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | waiting for the first operand of a group
// ACCUM   | compressing further operands into (sum, carry)
// RESOLVE | sliced carry-propagate add, one CHUNK-bit slice per cycle
// DONE    | result presented, held until out_ready
module csa_accum_sequencer
   import csa_accum_pkg::*;
#(
   parameter  int N       = 32,
   parameter  int MAX_OPS = 16,
   parameter  int CHUNK   = 8,
   localparam int ACC_W   = calc_acc_w(N, MAX_OPS)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [N-1:0]     in_data,
   input  logic             in_last,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [ACC_W-1:0] out_result,
   output logic             out_trunc,
   output logic             out_sat
);

   // The resolver reads the low CHUNK bits of the accumulator, so ACC_W >= CHUNK.
   localparam int S      = calc_slices(ACC_W, CHUNK);
   localparam int LAST_W = ACC_W - (S - 1) * CHUNK;
   localparam int CNT_W  = calc_cnt_w(MAX_OPS);
   localparam int IDX_W  = calc_idx_w(S);

   state_t state_q, state_d;

   logic [ACC_W-1:0] sum_q, carry_q, result_q;
   logic [ACC_W-1:0] csa_sum, csa_carry;
   logic [CNT_W-1:0] count_q;
   logic [IDX_W-1:0] idx_q;
   logic             cin_q;
   logic             trunc_q;
   logic [CHUNK:0]   slice_add;
   logic             beat, close_grp, last_slice;

   assign beat       = in_valid & in_ready;
   assign close_grp  = in_last | (count_q == CNT_W'(MAX_OPS - 1));
   assign last_slice = (idx_q == IDX_W'(S - 1));

   csa_compress_3to2 #(.W(ACC_W)) u_compress (
      .a     (sum_q),
      .b     (carry_q),
      .c     (ACC_W'(in_data)),
      .sum   (csa_sum),
      .carry (csa_carry)
   );

   // During RESOLVE sum/carry shift right a slice per cycle, so the current
   // slice is always their low CHUNK bits.
   assign slice_add = {1'b0, sum_q[CHUNK-1:0]} + {1'b0, carry_q[CHUNK-1:0]}
                    + {{CHUNK{1'b0}}, cin_q};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d   = state_q;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      case (state_q)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) state_d = in_last ? RESOLVE : ACCUM;
         end
         ACCUM: begin
            in_ready = 1'b1;
            if (in_valid && close_grp) state_d = RESOLVE;
         end
         RESOLVE: begin
            if (last_slice) state_d = DONE;
         end
         DONE: begin
            out_valid = 1'b1;
            if (out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sum_q    <= '0;
         carry_q  <= '0;
         result_q <= '0;
         count_q  <= '0;
         idx_q    <= '0;
         cin_q    <= 1'b0;
         trunc_q  <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (beat) begin
                  sum_q   <= ACC_W'(in_data);
                  carry_q <= '0;
                  count_q <= CNT_W'(1);
                  idx_q   <= '0;
                  cin_q   <= 1'b0;
                  trunc_q <= 1'b0;
               end
            end
            ACCUM: begin
               if (beat) begin
                  sum_q   <= csa_sum;
                  carry_q <= csa_carry;
                  count_q <= count_q + CNT_W'(1);
                  if (close_grp) trunc_q <= ~in_last;
               end
            end
            RESOLVE: begin
               sum_q   <= sum_q >> CHUNK;
               carry_q <= carry_q >> CHUNK;
               cin_q   <= slice_add[CHUNK];
               idx_q   <= idx_q + IDX_W'(1);
               // Slices enter at the top and shift down; the final slice is
               // only LAST_W bits wide, so it shifts by LAST_W to land the
               // first slice at bit 0. Its carry out is dropped (mod 2^ACC_W).
               if (last_slice)
                  result_q <= ACC_W'({slice_add[CHUNK-1:0], result_q} >> LAST_W);
               else
                  result_q <= ACC_W'({slice_add[CHUNK-1:0], result_q} >> CHUNK);
            end
            DONE: begin
               if (out_ready) begin
                  trunc_q <= 1'b0;
                  count_q <= '0;
               end
            end
            default: ;
         endcase
      end
   end

   assign out_trunc = trunc_q;

`ifdef CSA_ACC_SAT_EN
   logic over_n;
   assign over_n     = |result_q[ACC_W-1:N];
   assign out_sat    = out_valid & over_n;
   assign out_result = (out_valid & over_n) ? ACC_W'({N{1'b1}}) : result_q;
`else
   assign out_sat    = 1'b0;
   assign out_result = result_q;
`endif

endmodule

// File: tb/tb_csa_accum_sequencer.sv
// tb_csa_accum_sequencer
//   Table-driven vectors, hand-written corner sequences and randomized groups
//   for csa_accum_sequencer. Expected totals come from plain integer sums of
//   the operands sent; saturation is applied when CSA_ACC_SAT_EN is defined.
module tb_csa_accum_sequencer;

   localparam int N       = 32;
   localparam int MAX_OPS = 16;
   localparam int CHUNK   = 8;
   localparam int ACC_W   = N + $clog2(MAX_OPS);
   localparam int S       = (ACC_W + CHUNK - 1) / CHUNK;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             in_valid = 1'b0;
   logic             in_last = 1'b0;
   logic             out_ready = 1'b0;
   logic [N-1:0]     in_data = '0;
   logic             in_ready, out_valid, out_trunc, out_sat;
   logic [ACC_W-1:0] out_result;

   always #5 clk = ~clk;

   csa_accum_sequencer #(.N(N), .MAX_OPS(MAX_OPS), .CHUNK(CHUNK)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_data    (in_data),
      .in_last    (in_last),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_result (out_result),
      .out_trunc  (out_trunc),
      .out_sat    (out_sat)
   );

   typedef struct {
      int               n;
      logic [N-1:0]     val;
      bit               last;
      int               gap;
      int               hold;
      logic [ACC_W-1:0] raw;
      bit               trunc;
   } vec_t;

   vec_t         tbl[6];
   int           n_cmp = 0;
   int           n_fail = 0;
   logic [N-1:0] ops[MAX_OPS];
   int           nops;
   bit           use_last;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic timeout_fail(input string name);
      n_cmp++;
      n_fail++;
      $display("FAIL %s: wait bound expired", name);
   endtask

   function automatic logic [ACC_W-1:0] sat_adjust(input logic [ACC_W-1:0] raw, output bit sat);
      sat = 1'b0;
`ifdef CSA_ACC_SAT_EN
      if (raw >= (ACC_W'(1) << N)) begin
         sat = 1'b1;
         return ACC_W'({N{1'b1}});
      end
`endif
      return raw;
   endfunction

   function automatic logic [ACC_W-1:0] model_sum();
      longint unsigned acc = 0;
      for (int i = 0; i < nops; i++) acc += longint'(ops[i]);
      return ACC_W'(acc % (64'd1 << ACC_W));
   endfunction

   // Sends ops[0..nops-1], waits for the result, checks latency, value and
   // stability while out_ready is held low, then completes the handshake.
   // Returns at posedge+1 of the handshake edge.
   task automatic run_group(input string tag, input int gap, input int hold,
                            input logic [ACC_W-1:0] exp_res, input bit exp_trunc,
                            input bit exp_sat, input bit pend);
      int t;
      int lat;
      for (int i = 0; i < nops; i++) begin
         in_valid = 1'b1;
         in_data  = ops[i];
         in_last  = use_last && (i == nops - 1);
         t = 0;
         @(negedge clk);
         while (!in_ready && t < 50) begin
            t++;
            @(negedge clk);
         end
         if (!in_ready) begin
            timeout_fail({tag, " accept"});
            in_valid = 1'b0;
            return;
         end
         @(posedge clk); #1;
         in_valid = 1'b0;
         in_last  = 1'b0;
         in_data  = $urandom;
         if (i != nops - 1) repeat (gap) begin @(posedge clk); #1; end
      end
      lat = 0;
      @(negedge clk);
      check({tag, " in_ready closed"}, 64'(in_ready), 64'(0));
      while (!out_valid && lat < 40) begin
         lat++;
         @(negedge clk);
      end
      if (!out_valid) begin
         timeout_fail({tag, " out_valid"});
         return;
      end
      check({tag, " latency"}, 64'(lat), 64'(S));
      check({tag, " result"}, 64'(out_result), 64'(exp_res));
      check({tag, " trunc/sat"}, 64'({out_trunc, out_sat}), 64'({exp_trunc, exp_sat}));
      if (pend) begin
         in_valid = 1'b1;
         in_data  = 32'd1;
         in_last  = 1'b1;
      end
      repeat (hold) begin
         @(negedge clk);
         check({tag, " hold stable"}, 64'({out_valid, in_ready, out_trunc, out_sat, out_result}),
               64'({1'b1, 1'b0, exp_trunc, exp_sat, exp_res}));
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      check({tag, " after handshake"}, 64'({out_valid, in_ready}), 64'(2'b01));
   endtask

   initial begin
      logic [ACC_W-1:0] exp_r;
      bit               exp_s;
      int               g, h;

      tbl[0] = '{1,  32'hFFFF_FFFF, 1'b1, 0, 0,  36'h0_FFFF_FFFF, 1'b0};
      tbl[1] = '{16, 32'hFFFF_FFFF, 1'b1, 0, 2,  36'hF_FFFF_FFF0, 1'b0};
      tbl[2] = '{16, 32'h0000_0001, 1'b0, 0, 0,  36'h0_0000_0010, 1'b1};
      tbl[3] = '{2,  32'h0000_0000, 1'b1, 1, 0,  36'h0_0000_0000, 1'b0};
      tbl[4] = '{4,  32'h8000_0000, 1'b1, 0, 10, 36'h2_0000_0000, 1'b0};
      tbl[5] = '{15, 32'hFFFF_FFFF, 1'b1, 0, 1,  36'hE_FFFF_FFF1, 1'b0};

      repeat (3) @(posedge clk);
      @(negedge clk);
      check("reset state", 64'({out_valid, in_ready, out_trunc, out_sat, out_result}),
            64'({1'b0, 1'b1, 1'b0, 1'b0, 36'h0}));
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;

      for (int v = 0; v < 6; v++) begin
         nops     = tbl[v].n;
         use_last = tbl[v].last;
         for (int i = 0; i < nops; i++) ops[i] = tbl[v].val;
         exp_r = sat_adjust(tbl[v].raw, exp_s);
         run_group($sformatf("vec%0d", v), tbl[v].gap, tbl[v].hold, exp_r, tbl[v].trunc, exp_s, 1'b0);
      end

      // 1, 2, 3 with two idle cycles between beats
      nops = 3; use_last = 1'b1;
      ops[0] = 32'd1; ops[1] = 32'd2; ops[2] = 32'd3;
      exp_r = sat_adjust(36'd6, exp_s);
      run_group("gapped123", 2, 0, exp_r, 1'b0, exp_s, 1'b0);

      // 17 ones without last: closes at 16, 17th waits through DONE and
      // starts a fresh group on its own.
      nops = 16; use_last = 1'b0;
      for (int i = 0; i < nops; i++) ops[i] = 32'd1;
      exp_r = sat_adjust(36'd16, exp_s);
      run_group("ones16", 0, 3, exp_r, 1'b1, exp_s, 1'b1);
      nops = 1; use_last = 1'b1; ops[0] = 32'd1;
      exp_r = sat_adjust(36'd1, exp_s);
      run_group("ones17th", 0, 0, exp_r, 1'b0, exp_s, 1'b0);

      // reset in the middle of RESOLVE
      in_valid = 1'b1; in_data = 32'd100; in_last = 1'b1;
      @(negedge clk);
      @(posedge clk); #1;
      in_valid = 1'b0; in_last = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b0;
      #1;
      check("reset mid-resolve", 64'({out_valid, in_ready, out_trunc, out_sat, out_result}),
            64'({1'b0, 1'b1, 1'b0, 1'b0, 36'h0}));
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      nops = 2; use_last = 1'b1; ops[0] = 32'd5; ops[1] = 32'd7;
      exp_r = sat_adjust(36'd12, exp_s);
      run_group("after reset", 0, 0, exp_r, 1'b0, exp_s, 1'b0);

      for (int r = 0; r < 25; r++) begin
         use_last = ($urandom_range(0, 4) != 0);
         nops     = use_last ? int'($urandom_range(1, MAX_OPS)) : MAX_OPS;
         for (int i = 0; i < nops; i++)
            ops[i] = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : 32'($urandom);
         g = $urandom_range(0, 2);
         h = $urandom_range(0, 3);
         exp_r = sat_adjust(model_sum(), exp_s);
         run_group($sformatf("rand%0d", r), g, h, exp_r, !use_last, exp_s, 1'b0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
